perceptron_train: RTL and testbench
===================================

PERCEPTRON_TRAIN -- requirements
Module: perceptron_train

Interface
REQ-001 Parameter N, default 3, number of inputs/weights (matches upstream weighted-sum stage).
REQ-002 Parameter SHIFT, default 4, learning-rate right-shift applied to each x_i.
REQ-003 Parameter W_INIT, default 18'sd0, reset value of every weight.
REQ-004 Parameter SETTLE, default 4, cycles waited after an update so upstream sum pipeline flushes stale results.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 sum_valid  in  1  sum/x/target/train_en valid this cycle.
REQ-009 sum  in  48  signed weighted sum from upstream stage.
REQ-010 x  in  18*N  signed inputs that produced sum; x_i = x[18*i +: 18].
REQ-011 target  in  1  desired class (1 = positive, 0 = negative).
REQ-012 train_en  in  1  1 = apply learning rule on misclassification.
REQ-013 ready  out  1  block accepts a sample this cycle.
REQ-014 y  out  1  registered classification result.
REQ-015 y_valid  out  1  one-cycle pulse, y updated.
REQ-016 w  out  18*N  signed weights, w_i = w[18*i +: 18], drives upstream w input.
REQ-017 update_done  out  1  one-cycle pulse, weight update and settle complete.
REQ-018 err_count  out  16  count of trained misclassifications, saturating at 16'hFFFF.

Function
REQ-019 FSM states SHALL be IDLE, EVAL, UPDATE, SETTLE; ready SHALL equal 1 only in IDLE.
REQ-020 IDLE: on sum_valid && ready at edge t0, capture sum, x, target, train_en; go EVAL.
REQ-021 sum_valid while ready=0 SHALL be ignored (no capture, no state change).
REQ-022 EVAL (one cycle): at edge t0+1 register y = (sum >= 0), sum = 0 classifies as 1; assert y_valid for exactly cycle t0+1.
REQ-023 EVAL exit: if train_en && y != target go UPDATE with index i=0 and increment err_count (saturating); else go IDLE.
REQ-024 UPDATE: one weight per cycle, i = 0..N-1; d_i = x_i >>> SHIFT (arithmetic); w_i <= w_i + d_i if target=1, w_i - d_i if target=0.
REQ-025 Weight arithmetic SHALL use 19-bit signed intermediate and saturate to [-131072, 131071].
REQ-026 After i = N-1 updated go SETTLE; weights not being updated hold value.
REQ-027 SETTLE: count SETTLE cycles; on last, pulse update_done for one cycle and return to IDLE (ready=1 next cycle).
REQ-028 Total busy time of a trained miss SHALL be 1 + N + SETTLE cycles from accept to ready.
REQ-029 y holds last value until next EVAL; w changes only in UPDATE.

Reset
REQ-030 rst_n low SHALL immediately (asynchronously) force state IDLE, every w_i = W_INIT, y=0, y_valid=0, update_done=0, err_count=0, captured registers 0.
REQ-031 Reset asserted mid-UPDATE or mid-SETTLE SHALL abandon the update; no partial-weight retention, no update_done pulse.
REQ-032 After rst_n rises, ready=1 in the first cycle.

Verification (N=3, SHIFT=0, W_INIT=0, SETTLE=2)
REQ-033 Reset: assert rst_n=0 -> w=0, err_count=0, y=0, ready=1 with no clock edge required.
REQ-034 Correct: sum=+100, target=1, train_en=1 -> y=1, y_valid pulse one cycle after accept, w unchanged, ready back next cycle.
REQ-035 Miss/increment: sum=-5, target=1, x={18'd10,18'd20,18'd30} -> y=0, w_0=30, w_1=20, w_2=10 after 3 UPDATE cycles, err_count=1, update_done 6 cycles after accept.
REQ-036 Zero boundary: sum=0, target=0, same x -> y=1, weights decremented by 30/20/10; train_en=0 variant -> weights unchanged, err_count unchanged.
REQ-037 Saturation: W_INIT=131000, x_0=1000, target=1 miss -> w_0=131071; target=0 with W_INIT=-131000 -> w_0=-131072.
REQ-038 Busy/reset: sum_valid pulsed during UPDATE -> ignored; rst_n low during UPDATE -> w=W_INIT, IDLE, no update_done.

Source files
------------

// File: rtl/perceptron_train_if.sv
// Sample/result bus between the weighted-sum stage and the perceptron trainer.
// The master side presents a sample. The slave side is the trainer, which
// returns the class and the trained weights.
interface perceptron_train_if #(
    parameter int N = 3
);
    logic                 sum_valid;
    logic signed [47:0]   sum;
    logic [18*N-1:0]      x;
    logic                 target;
    logic                 train_en;
    logic                 ready;
    logic                 y;
    logic                 y_valid;
    logic [18*N-1:0]      w;
    logic                 update_done;
    logic [15:0]          err_count;

    modport master (
        output sum_valid, sum, x, target, train_en,
        input  ready, y, y_valid, w, update_done, err_count
    );

    modport slave (
        input  sum_valid, sum, x, target, train_en,
        output ready, y, y_valid, w, update_done, err_count
    );
endinterface

// File: rtl/perceptron_train.sv
// Perceptron classifier and trainer.
// The block classifies one upstream weighted sum at a time. On a trained
// misclassification it walks the weights one per cycle using the
// perceptron rule, with saturating arithmetic. It then idles for SETTLE
// cycles so the upstream sum pipeline flushes results built on stale
// weights. N must match the N of the connected interface instance.
module perceptron_train #(
    parameter int                 N      = 3,
    parameter int                 SHIFT  = 4,
    parameter logic signed [17:0] W_INIT = 18'sd0,
    parameter int                 SETTLE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    perceptron_train_if.slave  bus
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    // A SETTLE of 0 behaves like 1: the done pulse needs one cycle of its own.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t                    state_q;
    logic signed [47:0]        sum_q;
    logic [18*N-1:0]           x_q;
    logic                      target_q;
    logic                      train_en_q;
    logic                      y_q;
    logic                      y_valid_q;
    logic                      update_done_q;
    logic [15:0]               err_count_q;
    logic [IDX_W-1:0]          idx_q;
    logic [CNT_W-1:0]          cnt_q;
    logic signed [17:0]        w_q [N];
    logic signed [17:0]        w_d [N];
    logic [18*N-1:0]           w_pack;
    logic                      y_d;
    logic                      miss_d;

    // Clamp a 19-bit intermediate into the 18-bit signed weight range.
    function automatic logic signed [17:0] sat18(input logic signed [18:0] v);
        if (v[18] != v[17]) begin
            return v[18] ? 18'sh20000 : 18'sh1FFFF;
        end
        return v[17:0];
    endfunction

    // One perceptron step for a single weight: w +/- (x >>> SHIFT), saturated.
    function automatic logic signed [17:0] step_w(input logic signed [17:0] wv,
                                                  input logic signed [17:0] xv,
                                                  input logic               up);
        logic signed [17:0] d;
        logic signed [18:0] s;
        d = xv >>> SHIFT;
        if (up) begin
            s = {wv[17], wv} + {d[17], d};
        end else begin
            s = {wv[17], wv} - {d[17], d};
        end
        return sat18(s);
    endfunction

    // Candidate new value for every weight. Only the indexed one is committed.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_d[k] = step_w(w_q[k], x_q[18*k +: 18], target_q);
        end
    end

    // Pack the weight array onto the flat output bus.
    always_comb begin
        w_pack = '0;
        for (int k = 0; k < N; k++) begin
            w_pack[18*k +: 18] = w_q[k];
        end
    end

    // Classification of the captured sum. A sum of zero counts as positive.
    assign y_d    = (sum_q >= 48'sd0);
    assign miss_d = train_en_q && (y_d != target_q);

    // Control FSM with registered outputs and the weight update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sum_q         <= '0;
            x_q           <= '0;
            target_q      <= 1'b0;
            train_en_q    <= 1'b0;
            y_q           <= 1'b0;
            y_valid_q     <= 1'b0;
            update_done_q <= 1'b0;
            err_count_q   <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            for (int k = 0; k < N; k++) begin
                w_q[k] <= W_INIT;
            end
        end else begin
            y_valid_q     <= 1'b0;
            update_done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.sum_valid) begin
                        sum_q      <= bus.sum;
                        x_q        <= bus.x;
                        target_q   <= bus.target;
                        train_en_q <= bus.train_en;
                        state_q    <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    y_q       <= y_d;
                    y_valid_q <= 1'b1;
                    if (miss_d) begin
                        idx_q <= '0;
                        if (err_count_q != 16'hFFFF) begin
                            err_count_q <= err_count_q + 16'd1;
                        end
                        state_q <= ST_UPDATE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_UPDATE: begin
                    for (int k = 0; k < N; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            w_q[k] <= w_d[k];
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_SETTLE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        update_done_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready       = (state_q == ST_IDLE);
    assign bus.y           = y_q;
    assign bus.y_valid     = y_valid_q;
    assign bus.w           = w_pack;
    assign bus.update_done = update_done_q;
    assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_perceptron_train.sv
// Directed testbench for perceptron_train (N=3, SHIFT=0, SETTLE=2), plus two
// extra instances preset near the weight limits for the saturation cases.
module tb_perceptron_train;

    logic clk = 1'b0;
    logic rst_n;

    int n_checks = 0;
    int n_err    = 0;

    perceptron_train_if #(.N(3)) bus ();
    perceptron_train_if #(.N(3)) ifp ();
    perceptron_train_if #(.N(3)) ifn ();

    perceptron_train #(.N(3), .SHIFT(0), .W_INIT(18'sd0), .SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    perceptron_train #(.N(3), .SHIFT(0), .W_INIT(18'sd131000), .SETTLE(2)) dut_p (
        .clk(clk), .rst_n(rst_n), .bus(ifp));
    perceptron_train #(.N(3), .SHIFT(0), .W_INIT(-18'sd131000), .SETTLE(2)) dut_n (
        .clk(clk), .rst_n(rst_n), .bus(ifn));

    always #5 clk = ~clk;

    localparam logic [53:0] X_A = {18'd10, 18'd20, 18'd30};

    // Per-transaction observations (cycle j = j-th falling edge after accept)
    int          yv_j, yv_n, ud_j, ud_n, rdy_j;
    logic        y_at, rdy0;
    logic [53:0] wsnap [0:12];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic signed [47:0] s, input logic [53:0] xv,
                        input logic tg, input logic te);
        @(negedge clk);
        bus.sum = s; bus.x = xv; bus.target = tg; bus.train_en = te; bus.sum_valid = 1'b1;
        @(negedge clk);
        bus.sum_valid = 1'b0;
    endtask

    task automatic run_txn(input logic signed [47:0] s, input logic [53:0] xv,
                           input logic tg, input logic te, input int inj_j);
        send(s, xv, tg, te);
        yv_j = -1; yv_n = 0; ud_j = -1; ud_n = 0; rdy_j = -1; y_at = 1'bx;
        rdy0 = bus.ready;
        wsnap[0] = bus.w;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            wsnap[j] = bus.w;
            if (bus.y_valid) begin
                yv_n++;
                if (yv_j < 0) begin yv_j = j; y_at = bus.y; end
            end
            if (bus.update_done) begin
                ud_n++;
                if (ud_j < 0) ud_j = j;
            end
            if (bus.ready && rdy_j < 0) rdy_j = j;
            if (inj_j > 0 && j == inj_j) begin
                bus.sum = 48'sd1000; bus.x = {3{18'd5}}; bus.target = 1'b0;
                bus.train_en = 1'b1; bus.sum_valid = 1'b1;
            end else if (inj_j > 0 && j == inj_j + 1) begin
                bus.sum_valid = 1'b0;
            end
        end
    endtask

    initial begin
        bus.sum_valid = 0; bus.sum = '0; bus.x = '0; bus.target = 0; bus.train_en = 0;
        ifp.sum_valid = 0; ifp.sum = '0; ifp.x = '0; ifp.target = 0; ifp.train_en = 0;
        ifn.sum_valid = 0; ifn.sum = '0; ifn.x = '0; ifn.target = 0; ifn.train_en = 0;
        rst_n = 1'b1;

        // Asynchronous reset, observed before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_w",        64'(bus.w), 64'd0);
        check("rst_err",      64'(bus.err_count), 64'd0);
        check("rst_y",        64'(bus.y), 64'd0);
        check("rst_ready",    64'(bus.ready), 64'd1);
        check("rst_yvalid",   64'(bus.y_valid), 64'd0);
        check("rst_udone",    64'(bus.update_done), 64'd0);
        check("rst_w_p",      64'(ifp.w[17:0]), 64'h1FFB8);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(bus.ready), 64'd1);

        // Correct classification: no update
        run_txn(48'sd100, X_A, 1'b1, 1'b1, 0);
        check("ok_busy",    64'(rdy0), 64'd0);
        check("ok_yv_j",    64'(yv_j), 64'd1);
        check("ok_yv_n",    64'(yv_n), 64'd1);
        check("ok_y",       64'(y_at), 64'd1);
        check("ok_rdy_j",   64'(rdy_j), 64'd1);
        check("ok_ud_n",    64'(ud_n), 64'd0);
        check("ok_w",       64'(bus.w), 64'd0);
        check("ok_err",     64'(bus.err_count), 64'd0);

        // Miss with target=1: weights increment one per cycle
        run_txn(-48'sd5, X_A, 1'b1, 1'b1, 0);
        check("miss_y",     64'(y_at), 64'd0);
        check("miss_yv_j",  64'(yv_j), 64'd1);
        check("miss_w_j1",  64'(wsnap[1]), 64'd0);
        check("miss_w_j2",  64'(wsnap[2]), 64'({18'd0, 18'd0, 18'd30}));
        check("miss_w_j3",  64'(wsnap[3]), 64'({18'd0, 18'd20, 18'd30}));
        check("miss_w_j4",  64'(wsnap[4]), 64'({18'd10, 18'd20, 18'd30}));
        check("miss_ud_j",  64'(ud_j), 64'd6);
        check("miss_ud_n",  64'(ud_n), 64'd1);
        check("miss_rdy_j", 64'(rdy_j), 64'd6);
        check("miss_err",   64'(bus.err_count), 64'd1);

        // sum=0 with target=0, training disabled: classified 1, no change
        run_txn(48'sd0, X_A, 1'b0, 1'b0, 0);
        check("z_noen_y",   64'(y_at), 64'd1);
        check("z_noen_w",   64'(bus.w), 64'({18'd10, 18'd20, 18'd30}));
        check("z_noen_err", 64'(bus.err_count), 64'd1);
        check("z_noen_ud",  64'(ud_n), 64'd0);
        check("z_noen_rdy", 64'(rdy_j), 64'd1);

        // sum=0 with target=0, training enabled: decrement back to zero
        run_txn(48'sd0, X_A, 1'b0, 1'b1, 0);
        check("z_y",        64'(y_at), 64'd1);
        check("z_w_j2",     64'(wsnap[2]), 64'({18'd10, 18'd20, 18'd0}));
        check("z_w",        64'(bus.w), 64'd0);
        check("z_err",      64'(bus.err_count), 64'd2);
        check("z_ud_j",     64'(ud_j), 64'd6);

        // sum_valid pulsed while busy in UPDATE must be ignored
        run_txn(-48'sd5, X_A, 1'b1, 1'b1, 3);
        check("busy_yv_n",  64'(yv_n), 64'd1);
        check("busy_ud_n",  64'(ud_n), 64'd1);
        check("busy_w",     64'(bus.w), 64'({18'd10, 18'd20, 18'd30}));
        check("busy_err",   64'(bus.err_count), 64'd3);
        check("busy_y",     64'(bus.y), 64'd0);

        // Reset during UPDATE: abandon, weights back to W_INIT, no done pulse
        send(-48'sd5, X_A, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("rup_w_mid",  64'(bus.w), 64'({18'd10, 18'd20, 18'd60}));
        rst_n = 1'b0;
        #1;
        check("rup_w",      64'(bus.w), 64'd0);
        check("rup_ready",  64'(bus.ready), 64'd1);
        check("rup_err",    64'(bus.err_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ud_n = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (bus.update_done) ud_n++;
        end
        check("rup_ud_n",   64'(ud_n), 64'd0);
        check("rup_w_end",  64'(bus.w), 64'd0);

        // Saturation at both ends of the weight range
        @(negedge clk);
        ifp.sum = -48'sd5; ifp.x = {18'd0, 18'd0, 18'd1000}; ifp.target = 1'b1;
        ifp.train_en = 1'b1; ifp.sum_valid = 1'b1;
        ifn.sum = 48'sd0;  ifn.x = {18'd0, 18'd0, 18'd1000}; ifn.target = 1'b0;
        ifn.train_en = 1'b1; ifn.sum_valid = 1'b1;
        @(negedge clk);
        ifp.sum_valid = 1'b0;
        ifn.sum_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("sat_p_w0",   64'(ifp.w[17:0]), 64'h1FFFF);
        check("sat_p_w1",   64'(ifp.w[35:18]), 64'h1FFB8);
        check("sat_p_err",  64'(ifp.err_count), 64'd1);
        check("sat_n_w0",   64'(ifn.w[17:0]), 64'h20000);
        check("sat_n_w1",   64'(ifn.w[35:18]), 64'h20048);
        check("sat_n_err",  64'(ifn.err_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
